rv32i_mem_arbiter: RTL
======================

# rv32i_mem_arbiter

Single-port memory arbiter for the unpipelined RV32I core. It shares one 32-bit memory bus between the instruction-fetch port, used in FETCH, and the load/store data port, used in MEMORYACCESS. It resolves simultaneous requests round-robin, registers all memory-side and response signals, and aborts transactions the memory never acknowledges via a watchdog counter.

## Interface
- TIMEOUT, 255: max cycles a granted transaction waits for i_mem_ack before abort; 0 disables the watchdog.
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_ibus_req  in  1  fetch request; held with address stable until o_ibus_ack.
- i_ibus_addr  in  32  fetch byte address.
- o_ibus_ack  out  1  one-cycle response pulse.
- o_ibus_err  out  1  timeout flag, valid only with o_ibus_ack.
- o_ibus_rdata  out  32  fetched word, valid with o_ibus_ack.
- i_dbus_req  in  1  load/store request; held with fields stable until o_dbus_ack.
- i_dbus_we  in  1  1 = store.
- i_dbus_wsel  in  4  byte-lane write enables.
- i_dbus_addr  in  32  data byte address.
- i_dbus_wdata  in  32  store data.
- o_dbus_ack, o_dbus_err, o_dbus_rdata  out  1/1/32  same meaning as the ibus outputs; rdata is 0 for stores.
- o_mem_req  out  1  memory transaction active.
- o_mem_we  out  1  write strobe.
- o_mem_wsel  out  4  byte lanes.
- o_mem_addr  out  32  address.
- o_mem_wdata  out  32  write data.
- i_mem_ack  in  1  memory completion; honoured only while o_mem_req=1.
- i_mem_rdata  in  32  read data, valid with i_mem_ack.

## Operation
- States: IDLE, GRANT_I, GRANT_D, DONE. Reset state is IDLE.
- IDLE, only ibus req: go to GRANT_I. Latch the address, set o_mem_we=0 and o_mem_wsel=4'hF.
- IDLE, only dbus req: go to GRANT_D. Latch the addr, we, wsel and wdata fields.
- IDLE, both requesting: grant the port not granted last. The last-grant register resets to "ibus", so the first tie goes to dbus. Last-grant updates on every grant.
- GRANT_x: o_mem_req=1 and the latched fields drive the bus.
  - On i_mem_ack: capture i_mem_rdata (0 if we=1) and go to DONE with ack=1, err=0.
  - On timeout: go to DONE with ack=1, err=1, rdata=0.
- Watchdog counter: cleared on grant, increments each GRANT cycle without ack. Timeout fires when it reaches TIMEOUT-1 with no ack.
- i_mem_ack and timeout in the same cycle: the ack wins and err=0.
- DONE: o_mem_req=0; the granted port's ack (and err) are high for exactly this cycle. Requests are ignored in DONE. Next state is always IDLE.
- Requesters drop req, or present a new request, no earlier than the cycle after ack. A req still high in IDLE is treated as a new request.
- i_mem_ack outside GRANT_x is ignored.
- Async reset at any time: state IDLE, last-grant ibus, counter 0, all outputs 0. The in-flight transaction is discarded and no ack is issued.

## Timing
- Reset values: all outputs 0, including o_mem_wsel=0.
- Request seen high in IDLE at cycle 0: o_mem_req rises in cycle 1.
- Zero-wait memory (ack in cycle 1): o_x_ack in cycle 2, back to IDLE in cycle 3. The earliest next grant is visible on o_mem_req in cycle 4, for a minimum of 3 cycles per access.
- N memory wait cycles add N cycles.
- Timeout: with TIMEOUT=T, a grant in cycle 1 gives ack+err in cycle T+1.
- All outputs are registered, with no combinational path from any input to any output.

## Structure
- Shared header asrv32_header.vh holds the state encodings (ARB_IDLE=0, ARB_GRANT_I=1, ARB_GRANT_D=2, ARB_DONE=3) and the default TIMEOUT.
- The watchdog is a natural sub-module, rv32i_arb_watchdog: clear, enable, TIMEOUT parameter, expire output.
- Everything else stays flat in one module.

## Test plan
- ibus alone, addr 0x0000_0100, memory acks in cycle 1 with 0x0000_0013: o_mem_req cycle 1 with we=0, wsel=F; o_ibus_ack=1 with rdata 0x13 in cycle 2; no dbus ack.
- dbus store, addr 0x200, wdata 0xDEADBEEF, wsel 4'b0011, 2 wait cycles: o_mem_* fields match; o_dbus_ack in cycle 4 with rdata=0 and err=0.
- Both requests in cycle 0 after reset: dbus granted first, then ibus granted with o_mem_req in cycle 4; with both held continuously, grants alternate D, I, D, I.
- TIMEOUT=4, memory never acks: o_dbus_ack=1, err=1, rdata=0 in cycle 5; ack arriving exactly at expiry gives err=0 with the real rdata.
- i_rst_n low during GRANT_I with ack pending: all outputs 0 immediately; no o_ibus_ack after release; the next request is served normally from IDLE.
- Spurious i_mem_ack in IDLE/DONE: no state change and no response pulse.

Source files
------------

// File: rtl/rv32i_mem_arbiter_pkg.sv
// Shared definitions for the RV32I fetch/load-store memory arbiter:
// FSM state encodings, last-grant tag and the default watchdog limit.
package rv32i_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT_I = 2'd1,
    ARB_GRANT_D = 2'd2,
    ARB_DONE    = 2'd3
  } arb_state_e;

  typedef enum logic {
    LAST_IBUS = 1'b0,
    LAST_DBUS = 1'b1
  } arb_port_e;

  localparam int unsigned ARB_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/rv32i_arb_watchdog.sv
// Transaction watchdog: counts enabled cycles since the last clear and
// flags expiry on the TIMEOUT-th enabled cycle. TIMEOUT=0 never expires.
module rv32i_arb_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clear)       cnt_d = '0;
    else if (i_enable) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign o_expire = (TIMEOUT != 0) && i_enable && (cnt_q == LAST);

endmodule

// File: rtl/rv32i_mem_arbiter.sv
// Single-port memory arbiter sharing one bus between instruction fetch and
// load/store, with round-robin tie-break and a watchdog abort. All outputs registered.
module rv32i_mem_arbiter
  import rv32i_mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_ibus_req,
  input  logic [31:0] i_ibus_addr,
  output logic        o_ibus_ack,
  output logic        o_ibus_err,
  output logic [31:0] o_ibus_rdata,
  input  logic        i_dbus_req,
  input  logic        i_dbus_we,
  input  logic [3:0]  i_dbus_wsel,
  input  logic [31:0] i_dbus_addr,
  input  logic [31:0] i_dbus_wdata,
  output logic        o_dbus_ack,
  output logic        o_dbus_err,
  output logic [31:0] o_dbus_rdata,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [3:0]  o_mem_wsel,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata
);

  arb_state_e  state_q, state_d;
  arb_port_e   last_q, last_d;
  logic        mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [3:0]  mem_wsel_q, mem_wsel_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic        ibus_ack_q, ibus_ack_d, ibus_err_q, ibus_err_d;
  logic        dbus_ack_q, dbus_ack_d, dbus_err_q, dbus_err_d;
  logic [31:0] ibus_rdata_q, ibus_rdata_d, dbus_rdata_q, dbus_rdata_d;

  logic in_grant, expire;

  assign in_grant = (state_q == ARB_GRANT_I) || (state_q == ARB_GRANT_D);

  rv32i_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clear  (!in_grant),
    .i_enable (in_grant && !i_mem_ack),
    .o_expire (expire)
  );

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_wsel_d   = mem_wsel_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    ibus_ack_d   = 1'b0;
    ibus_err_d   = 1'b0;
    ibus_rdata_d = ibus_rdata_q;
    dbus_ack_d   = 1'b0;
    dbus_err_d   = 1'b0;
    dbus_rdata_d = dbus_rdata_q;

    unique case (state_q)
      ARB_IDLE: begin
        // On a tie, the port that did not win last time gets the bus
        if (i_ibus_req && (!i_dbus_req || last_q == LAST_DBUS)) begin
          state_d     = ARB_GRANT_I;
          last_d      = LAST_IBUS;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_wsel_d  = 4'hF;
          mem_addr_d  = i_ibus_addr;
          mem_wdata_d = '0;
        end else if (i_dbus_req) begin
          state_d     = ARB_GRANT_D;
          last_d      = LAST_DBUS;
          mem_req_d   = 1'b1;
          mem_we_d    = i_dbus_we;
          mem_wsel_d  = i_dbus_wsel;
          mem_addr_d  = i_dbus_addr;
          mem_wdata_d = i_dbus_wdata;
        end
      end
      ARB_GRANT_I, ARB_GRANT_D: begin
        if (i_mem_ack || expire) begin
          state_d   = ARB_DONE;
          mem_req_d = 1'b0;
          if (state_q == ARB_GRANT_I) begin
            ibus_ack_d   = 1'b1;
            ibus_err_d   = !i_mem_ack;
            ibus_rdata_d = i_mem_ack ? i_mem_rdata : '0;
          end else begin
            dbus_ack_d   = 1'b1;
            dbus_err_d   = !i_mem_ack;
            dbus_rdata_d = (i_mem_ack && !mem_we_q) ? i_mem_rdata : '0;
          end
        end
      end
      ARB_DONE: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ARB_IDLE;
      last_q       <= LAST_IBUS;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_wsel_q   <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      ibus_ack_q   <= 1'b0;
      ibus_err_q   <= 1'b0;
      ibus_rdata_q <= '0;
      dbus_ack_q   <= 1'b0;
      dbus_err_q   <= 1'b0;
      dbus_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_wsel_q   <= mem_wsel_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      ibus_ack_q   <= ibus_ack_d;
      ibus_err_q   <= ibus_err_d;
      ibus_rdata_q <= ibus_rdata_d;
      dbus_ack_q   <= dbus_ack_d;
      dbus_err_q   <= dbus_err_d;
      dbus_rdata_q <= dbus_rdata_d;
    end
  end

  assign o_mem_req    = mem_req_q;
  assign o_mem_we     = mem_we_q;
  assign o_mem_wsel   = mem_wsel_q;
  assign o_mem_addr   = mem_addr_q;
  assign o_mem_wdata  = mem_wdata_q;
  assign o_ibus_ack   = ibus_ack_q;
  assign o_ibus_err   = ibus_err_q;
  assign o_ibus_rdata = ibus_rdata_q;
  assign o_dbus_ack   = dbus_ack_q;
  assign o_dbus_err   = dbus_err_q;
  assign o_dbus_rdata = dbus_rdata_q;

endmodule
